cdc_gray_count_rx: RTL and testbench
====================================

# cdc_gray_count_rx

Destination-domain consumer of a Gray-coded counter that has crossed clock domains through `cdc_sync_bits`. It decodes the synchronised Gray value to binary and computes the per-cycle increment modulo 2^GRAY_BITS. It accumulates that increment into a wide timestamp for the sample packer. Increments too large to be unambiguous are flagged as overruns.

## Interface
- GRAY_BITS, 4: width of the synchronised Gray count; must be ≥ 2.
- TS_WIDTH, 64: width of the accumulated timestamp; must be > GRAY_BITS.
- MAX_DELTA, 2^(GRAY_BITS-1)-1: largest increment accepted per cycle.

Clock and reset:
- clk_out  in  1: the only clock; all logic runs on its rising edge.
- reset  in  1: asynchronous, active-high.

Data and control:
- gray_in  in  GRAY_BITS: synchronised Gray count, driven by `cdc_sync_bits.bits_out`.
- enable  in  1: when high, increments accumulate into ts_out.
- load  in  1: synchronous load of ts_load into ts_out.
- ts_load  in  TS_WIDTH: value loaded into ts_out.
- overrun_clr  in  1: clears the sticky overrun flag.
- ts_out  out  TS_WIDTH: accumulated timestamp.
- ts_valid  out  1: one-cycle pulse when ts_out advanced by a nonzero delta.
- delta_out  out  GRAY_BITS: delta applied on the last cycle.
- overrun  out  1: sticky flag; set when a delta exceeds MAX_DELTA.

## Operation
- Stage 1: r_bin <= gray_to_bin(gray_in) every cycle.
- State FILL: entered on reset; lasts one cycle; goes to PRIME.
- State PRIME: bin_prev <= r_bin. Goes to RUN if enable is high, else IDLE.
- State IDLE:
  - bin_prev <= r_bin every cycle; ts_out holds; ts_valid=0; delta_out=0.
  - enable=1 → RUN.
  - Re-enabling therefore never produces a jump.
- State RUN:
  - delta = (r_bin - bin_prev) mod 2^GRAY_BITS; bin_prev <= r_bin.
  - If 0 < delta ≤ MAX_DELTA: ts_out <= ts_out + zero-extended delta; ts_valid <= 1; delta_out <= delta.
  - If delta = 0: ts_out holds; ts_valid <= 0; delta_out <= 0.
  - If delta > MAX_DELTA: ts_out holds; overrun <= 1; ts_valid <= 0; delta_out <= delta.
  - enable=0 → IDLE; the delta computed in that same cycle is still applied.
- Wrap rules:
  - ts_out wraps modulo 2^TS_WIDTH with no flag.
  - Gray wrap (e.g. 15→0) is a delta of 1.
- load:
  - Honoured in every state except FILL; ts_out <= ts_load; ts_valid <= 0.
  - Load beats accumulation in the same cycle: that cycle's delta is discarded, but bin_prev still updates.
- overrun_clr clears overrun. If a new overrun occurs in the same cycle, set wins.

## Timing
- Reset values, applied immediately on assertion:
  - ts_out 0, ts_valid 0, delta_out 0, overrun 0.
  - r_bin 0, bin_prev 0, state FILL.
- Latency: gray_in sampled at edge N → ts_out/ts_valid/delta_out updated at edge N+1.
- After reset release, the first accumulation is possible at the third rising edge.
- Reset asserted mid-operation: accumulated state is lost and the sequence restarts at FILL. No partial update survives.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- CDC_GRAY_COUNT_RX_OVERRUN_CNT_EN defined:
  - Adds output overrun_count (16 bits).
  - Increments on every overrun cycle and saturates at 0xFFFF.
  - Cleared by overrun_clr; increment wins over a simultaneous clear, leaving the count at 1.
  - Reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package cdc_pkg holds:
  - the state enum typedef (FILL, PRIME, IDLE, RUN);
  - the default-MAX_DELTA computation function.
- One sub-module, gray_to_bin: purely combinational, parameterised by width, instanced once for stage 1.

## Test plan
- Gray walk: GRAY_BITS=4, enable=1, gray_in steps one count per cycle 0→15→0 for 20 cycles. Required: ts_out=20, ts_valid high on every advancing cycle, delta_out=1.
- Skip: gray_in jumps binary 3→6. Required: delta_out=3, ts_out +3, overrun stays 0.
- Overrun: binary 2→10 (delta 8 > MAX_DELTA 7). Required: overrun=1, ts_out unchanged. Then overrun_clr pulse → 0. Overrun coincident with overrun_clr → stays 1.
- Load collision: load=1 with ts_load=0x1000 in a cycle where delta=2. Required: ts_out=0x1000, ts_valid=0. The next +1 step gives 0x1001.
- Enable gap: enable low while count advances by 5, then high. Required: ts_out unchanged and no ts_valid pulse while disabled or on re-enable.
- Reset mid-run: reset asserted with ts_out=0x55. Required: immediate zeroing. After release with gray_in held at binary 9, ts_out stays 0 (PRIME absorbs the offset).

Source files
------------

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and helpers for the Gray-count receiver.
// Holds the receiver state enum and the default MAX_DELTA computation.
package cdc_pkg;

  // Receiver sequencing states.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    IDLE  = 2'd2,
    RUN   = 2'd3
  } state_e;

  // Largest unambiguous increment for a Gray counter of the given width:
  // half the code space minus one.
  function automatic int default_max_delta(input int gray_bits);
    return (32'sd1 <<< (gray_bits - 32'sd1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/cdc_gray_count_rx_gray_to_bin.sv
// gray_to_bin: purely combinational Gray-to-binary decoder.
// Each binary bit is the XOR reduction of the Gray bits at and above it.
module gray_to_bin #(
  parameter int unsigned W = 32'd4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/cdc_gray_count_rx.sv
// cdc_gray_count_rx: destination-domain consumer of a synchronised Gray
// counter. Decodes the count, derives the per-cycle increment and
// accumulates it into a wide timestamp; oversized increments raise a
// sticky overrun flag.
// Optional feature: define CDC_GRAY_COUNT_RX_OVERRUN_CNT_EN to add the
// saturating 16-bit overrun_count output.
module cdc_gray_count_rx
  import cdc_pkg::*;
#(
  parameter int unsigned GRAY_BITS = 32'd4,
  parameter int unsigned TS_WIDTH  = 32'd64,
  parameter int          MAX_DELTA = default_max_delta(GRAY_BITS)
) (
  input  logic                 clk_out,
  input  logic                 reset,
  input  logic [GRAY_BITS-1:0] gray_in,
  input  logic                 enable,
  input  logic                 load,
  input  logic [TS_WIDTH-1:0]  ts_load,
  input  logic                 overrun_clr,
  output logic [TS_WIDTH-1:0]  ts_out,
  output logic                 ts_valid,
  output logic [GRAY_BITS-1:0] delta_out,
`ifdef CDC_GRAY_COUNT_RX_OVERRUN_CNT_EN
  output logic [15:0]          overrun_count,
`endif
  output logic                 overrun
);

  localparam logic [GRAY_BITS-1:0] LP_MAX_DELTA = GRAY_BITS'(MAX_DELTA);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [GRAY_BITS-1:0]  w_bin_dec;
  logic [GRAY_BITS-1:0]  r_bin;
  logic [GRAY_BITS-1:0]  r_bin_prev;
  logic [GRAY_BITS-1:0]  w_bin_prev_nxt;
  logic [GRAY_BITS-1:0]  w_delta;
  logic [TS_WIDTH-1:0]   r_ts;
  logic [TS_WIDTH-1:0]   w_ts_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic [GRAY_BITS-1:0]  r_delta_out;
  logic [GRAY_BITS-1:0]  w_delta_out_nxt;
  logic                  r_ovr;
  logic                  w_ovr_nxt;
  logic                  w_ovr_set;

  gray_to_bin #(
    .W (GRAY_BITS)
  ) u_gray_to_bin (
    .i_gray (gray_in),
    .o_bin  (w_bin_dec)
  );

  // Modular difference between the newest sample and the previous one.
  assign w_delta = r_bin - r_bin_prev;

  // State register: FILL after reset, then follows the next-state logic.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: after FILL/PRIME the state tracks enable directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    w_state_nxt = PRIME;
      PRIME:   w_state_nxt = enable ? RUN : IDLE;
      IDLE:    w_state_nxt = enable ? RUN : IDLE;
      RUN:     w_state_nxt = enable ? RUN : IDLE;
      default: w_state_nxt = FILL;
    endcase
  end

  // Output/datapath logic: accumulate in RUN, load overrides accumulation.
  always_comb begin
    w_ts_nxt        = r_ts;
    w_valid_nxt     = 1'b0;
    w_delta_out_nxt = '0;
    w_ovr_set       = 1'b0;
    w_bin_prev_nxt  = r_bin_prev;
    case (r_state)
      FILL: begin
        w_bin_prev_nxt = r_bin_prev;
      end
      PRIME, IDLE: begin
        // Re-basing here is what keeps re-enable free of jumps.
        w_bin_prev_nxt = r_bin;
      end
      RUN: begin
        w_bin_prev_nxt = r_bin;
        if (w_delta == '0) begin
          w_delta_out_nxt = '0;
        end else if (w_delta <= LP_MAX_DELTA) begin
          w_ts_nxt        = r_ts + {{(TS_WIDTH-GRAY_BITS){1'b0}}, w_delta};
          w_valid_nxt     = 1'b1;
          w_delta_out_nxt = w_delta;
        end else begin
          w_ovr_set       = 1'b1;
          w_delta_out_nxt = w_delta;
        end
      end
      default: begin
        w_bin_prev_nxt = r_bin_prev;
      end
    endcase
    // A load discards this cycle's delta entirely; bin_prev still advances.
    if (load && (r_state != FILL)) begin
      w_ts_nxt        = ts_load;
      w_valid_nxt     = 1'b0;
      w_delta_out_nxt = '0;
      w_ovr_set       = 1'b0;
    end else begin
      w_ts_nxt = w_ts_nxt;
    end
    // Sticky overrun: a new event wins over a clear in the same cycle.
    if (w_ovr_set) begin
      w_ovr_nxt = 1'b1;
    end else if (overrun_clr) begin
      w_ovr_nxt = 1'b0;
    end else begin
      w_ovr_nxt = r_ovr;
    end
  end

  // Datapath registers: decoded sample, previous sample and all outputs.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      r_bin       <= '0;
      r_bin_prev  <= '0;
      r_ts        <= '0;
      r_valid     <= 1'b0;
      r_delta_out <= '0;
      r_ovr       <= 1'b0;
    end else begin
      r_bin       <= w_bin_dec;
      r_bin_prev  <= w_bin_prev_nxt;
      r_ts        <= w_ts_nxt;
      r_valid     <= w_valid_nxt;
      r_delta_out <= w_delta_out_nxt;
      r_ovr       <= w_ovr_nxt;
    end
  end

  assign ts_out    = r_ts;
  assign ts_valid  = r_valid;
  assign delta_out = r_delta_out;
  assign overrun   = r_ovr;

`ifdef CDC_GRAY_COUNT_RX_OVERRUN_CNT_EN
  logic [15:0] r_ovr_cnt;
  logic [15:0] w_ovr_cnt_nxt;

  // Overrun counter next value: saturating increment, increment beats clear.
  always_comb begin
    if (w_ovr_set) begin
      if (overrun_clr) begin
        w_ovr_cnt_nxt = 16'd1;
      end else if (r_ovr_cnt == 16'hFFFF) begin
        w_ovr_cnt_nxt = r_ovr_cnt;
      end else begin
        w_ovr_cnt_nxt = r_ovr_cnt + 16'd1;
      end
    end else if (overrun_clr) begin
      w_ovr_cnt_nxt = 16'd0;
    end else begin
      w_ovr_cnt_nxt = r_ovr_cnt;
    end
  end

  // Overrun counter register.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      r_ovr_cnt <= 16'd0;
    end else begin
      r_ovr_cnt <= w_ovr_cnt_nxt;
    end
  end

  assign overrun_count = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_cdc_gray_count_rx.sv
// tb_cdc_gray_count_rx: directed plus randomized bench with a behavioural
// reference model expressed in terms of sample history and enable history.
module tb_cdc_gray_count_rx;

  logic        clk_out = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  gray_in = 4'd0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [63:0] ts_load = 64'd0;
  logic        overrun_clr = 1'b0;
  logic [63:0] ts_out;
  logic        ts_valid;
  logic [3:0]  delta_out;
  logic        overrun;
`ifdef CDC_GRAY_COUNT_RX_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  int checks = 0;
  int failures = 0;
  logic chk_on = 1'b0;

  logic [3:0]  cur_bin = 4'd0;

  // reference model state
  int          edge_n = 0;
  logic [3:0]  s1 = 4'd0;
  logic [3:0]  s2 = 4'd0;
  logic        en_prev = 1'b0;
  logic [63:0] m_ts = 64'd0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_dout = 4'd0;
  logic        m_ovr = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  cdc_gray_count_rx dut (
    .clk_out       (clk_out),
    .reset         (reset),
    .gray_in       (gray_in),
    .enable        (enable),
    .load          (load),
    .ts_load       (ts_load),
    .overrun_clr   (overrun_clr),
    .ts_out        (ts_out),
    .ts_valid      (ts_valid),
    .delta_out     (delta_out),
`ifdef CDC_GRAY_COUNT_RX_OVERRUN_CNT_EN
    .overrun_count (overrun_count),
`endif
    .overrun       (overrun)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // literal expectation applied to both the DUT and the model
  task automatic lit(input string name, input logic [63:0] dut_v, input logic [63:0] mod_v, input logic [63:0] exp);
    chk(name, dut_v, exp);
    chk({name, "_model"}, mod_v, exp);
  endtask

  task automatic model_clear();
    edge_n = 0; s1 = 4'd0; s2 = 4'd0; en_prev = 1'b0;
    m_ts = 64'd0; m_valid = 1'b0; m_dout = 4'd0; m_ovr = 1'b0; m_cnt = 16'd0;
  endtask

  // One rising edge: the increment between the two previous samples is
  // applied when enable was high on the previous edge (from edge 3 on).
  task automatic model_step();
    logic [3:0] d;
    logic ev;
    edge_n = edge_n + 1;
    d = s1 - s2;
    ev = 1'b0;
    m_valid = 1'b0;
    m_dout = 4'd0;
    if (edge_n >= 3 && en_prev) begin
      if (d != 4'd0 && d <= 4'd7) begin
        m_ts = m_ts + 64'(d); m_valid = 1'b1; m_dout = d;
      end else if (d > 4'd7) begin
        ev = 1'b1; m_dout = d;
      end
    end
    if (load && edge_n >= 2) begin
      m_ts = ts_load; m_valid = 1'b0; m_dout = 4'd0; ev = 1'b0;
    end
    if (ev) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    if (ev) m_cnt = overrun_clr ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
    else if (overrun_clr) m_cnt = 16'd0;
    s2 = s1;
    s1 = cur_bin;
    en_prev = enable;
  endtask

  initial forever begin
    @(posedge clk_out or posedge reset);
    if (reset) model_clear();
    else model_step();
  end

  // single compare process, every falling edge once checking is armed
  initial forever begin
    @(negedge clk_out);
    if (chk_on) begin
      chk("ts_out", ts_out, m_ts);
      chk("ts_valid", {63'd0, ts_valid}, {63'd0, m_valid});
      chk("delta_out", {60'd0, delta_out}, {60'd0, m_dout});
      chk("overrun", {63'd0, overrun}, {63'd0, m_ovr});
`ifdef CDC_GRAY_COUNT_RX_OVERRUN_CNT_EN
      chk("overrun_count", {48'd0, overrun_count}, {48'd0, m_cnt});
`endif
    end
  end

  task automatic step(input logic [3:0] b, input logic e, input logic l, input logic [63:0] lv, input logic c);
    @(negedge clk_out);
    cur_bin = b;
    gray_in = b ^ (b >> 1);
    enable = e;
    load = l;
    ts_load = lv;
    overrun_clr = c;
    @(posedge clk_out);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] hold_bin);
    @(negedge clk_out);
    #2;
    reset = 1'b1;
    cur_bin = hold_bin;
    gray_in = hold_bin ^ (hold_bin >> 1);
    enable = 1'b1; load = 1'b0; overrun_clr = 1'b0; ts_load = 64'd0;
    #1;
    chk_on = 1'b1;
    lit("rst_ts_out", ts_out, m_ts, 64'd0);
    lit("rst_ts_valid", {63'd0, ts_valid}, {63'd0, m_valid}, 64'd0);
    lit("rst_delta_out", {60'd0, delta_out}, {60'd0, m_dout}, 64'd0);
    lit("rst_overrun", {63'd0, overrun}, {63'd0, m_ovr}, 64'd0);
    @(negedge clk_out);
    @(negedge clk_out);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0]  rb;
    logic [63:0] lv;
    do_reset(4'd0);

    // Gray walk: edge 1 samples 0, then one count per edge incl. 15->0
    for (int k = 2; k <= 22; k++) step(4'((k - 1) % 16), 1'b1, 1'b0, 64'd0, 1'b0);
    lit("walk_ts", ts_out, m_ts, 64'd20);
    lit("walk_delta", {60'd0, delta_out}, {60'd0, m_dout}, 64'd1);
    lit("walk_valid", {63'd0, ts_valid}, {63'd0, m_valid}, 64'd1);

    // Skip: ... 12 -> 3 -> 6 gives +7 then +3
    step(4'd12, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd3, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd6, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd6, 1'b1, 1'b0, 64'd0, 1'b0);
    lit("skip_ts", ts_out, m_ts, 64'd38);
    lit("skip_delta", {60'd0, delta_out}, {60'd0, m_dout}, 64'd3);
    lit("skip_ovr", {63'd0, overrun}, {63'd0, m_ovr}, 64'd0);
    step(4'd6, 1'b1, 1'b0, 64'd0, 1'b0);
    lit("hold_valid", {63'd0, ts_valid}, {63'd0, m_valid}, 64'd0);

    // Overrun: 13 -> 2 -> 10 (delta 8)
    step(4'd13, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd2, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd10, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd10, 1'b1, 1'b0, 64'd0, 1'b0);
    lit("ovr_set", {63'd0, overrun}, {63'd0, m_ovr}, 64'd1);
    lit("ovr_ts", ts_out, m_ts, 64'd50);
    lit("ovr_delta", {60'd0, delta_out}, {60'd0, m_dout}, 64'd8);
    step(4'd10, 1'b1, 1'b0, 64'd0, 1'b1);
    lit("ovr_clr", {63'd0, overrun}, {63'd0, m_ovr}, 64'd0);
    step(4'd10, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd2, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd2, 1'b1, 1'b0, 64'd0, 1'b1);
    lit("ovr_set_wins", {63'd0, overrun}, {63'd0, m_ovr}, 64'd1);
    lit("ovr_set_wins_ts", ts_out, m_ts, 64'd50);
`ifdef CDC_GRAY_COUNT_RX_OVERRUN_CNT_EN
    lit("ovr_cnt_one", {48'd0, overrun_count}, {48'd0, m_cnt}, 64'd1);
`endif
    step(4'd2, 1'b1, 1'b0, 64'd0, 1'b1);
    lit("ovr_clr2", {63'd0, overrun}, {63'd0, m_ovr}, 64'd0);

    // Load collision: load in the cycle whose delta is 2
    step(4'd4, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd5, 1'b1, 1'b1, 64'h1000, 1'b0);
    lit("load_ts", ts_out, m_ts, 64'h1000);
    lit("load_valid", {63'd0, ts_valid}, {63'd0, m_valid}, 64'd0);
    step(4'd5, 1'b1, 1'b0, 64'd0, 1'b0);
    lit("load_next", ts_out, m_ts, 64'h1001);

    // Enable gap: count advances by 5 while disabled
    step(4'd5, 1'b0, 1'b0, 64'd0, 1'b0);
    step(4'd7, 1'b0, 1'b0, 64'd0, 1'b0);
    step(4'd10, 1'b0, 1'b0, 64'd0, 1'b0);
    lit("gap_ts", ts_out, m_ts, 64'h1001);
    step(4'd10, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd10, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd11, 1'b1, 1'b0, 64'd0, 1'b0);
    lit("reen_ts", ts_out, m_ts, 64'h1001);
    lit("reen_valid", {63'd0, ts_valid}, {63'd0, m_valid}, 64'd0);
    step(4'd11, 1'b1, 1'b0, 64'd0, 1'b0);
    lit("reen_step", ts_out, m_ts, 64'h1002);

    // Reset mid-run with ts_out = 0x55, then hold binary 9
    step(4'd11, 1'b1, 1'b1, 64'h55, 1'b0);
    step(4'd11, 1'b1, 1'b0, 64'd0, 1'b0);
    lit("pre_rst_ts", ts_out, m_ts, 64'h55);
    do_reset(4'd9);
    for (int k = 2; k <= 5; k++) step(4'd9, 1'b1, 1'b0, 64'd0, 1'b0);
    lit("prime_ts", ts_out, m_ts, 64'd0);

    // Timestamp wrap modulo 2^64
    step(4'd9, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    step(4'd12, 1'b1, 1'b0, 64'd0, 1'b0);
    step(4'd12, 1'b1, 1'b0, 64'd0, 1'b0);
    lit("wrap_ts", ts_out, m_ts, 64'd1);
    lit("wrap_valid", {63'd0, ts_valid}, {63'd0, m_valid}, 64'd1);

    // Randomized traffic
    rb = 4'd12;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rb = 4'($urandom_range(0, 15));
        do_reset(rb);
      end
      if ($urandom_range(0, 99) < 8) rb = 4'($urandom_range(0, 15));
      else rb = rb + 4'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) lv = {$urandom, $urandom};
      else lv = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      step(rb, ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0), lv, ($urandom_range(0, 15) == 0));
    end

    @(negedge clk_out);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
